// File: rtl/gb_mem_arbiter_pkg.sv
// Shared types for the GameBoy memory arbiter: FSM states, grant source and open-bus value.
package gb_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DMA = 1'b1
  } grant_src_t;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/gb_mem_arbiter_if.sv
// CPU bus, DMA requester and memory port bundled for the arbiter.
// master = surrounding system (CPU wrapper, DMA engine, SDRAM front end), slave = the arbiter.
interface gb_mem_arbiter_if #(
  parameter int AW = 16
);
  logic          cpu_mreq_n;
  logic          cpu_rd_n;
  logic          cpu_wr_n;
  logic [AW-1:0] cpu_a;
  logic [7:0]    cpu_do;
  logic [7:0]    cpu_di;
  logic          cpu_wait_n;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_wdata;
  logic [7:0]    dma_rdata;
  logic          dma_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          mem_ack;

  logic          timeout_err;

  modport master (
    output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_a, cpu_do,
    input  cpu_di, cpu_wait_n,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  timeout_err
  );

  modport slave (
    input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_a, cpu_do,
    output cpu_di, cpu_wait_n,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output timeout_err
  );

endinterface

// File: rtl/gb_mem_arbiter_strobe.sv
// CPU strobe edge detect and request capture; WAIT_n drops combinationally on the strobe edge
// and rises the cycle after completion.
module gb_cpu_strobe_capture #(
  parameter int AW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_mreq_n,
  input  logic          i_rd_n,
  input  logic          i_wr_n,
  input  logic [AW-1:0] i_a,
  input  logic [7:0]    i_do,
  input  logic          i_complete,
  output logic          o_req,
  output logic          o_wait_n,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_wdata,
  output logic          o_we
);

  logic          w_strb;
  logic          w_start;
  logic          r_strobe_q;
  logic          r_pend;
  logic          r_done;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;
  logic          r_we;

  assign w_strb  = ~i_mreq_n & (~i_rd_n | ~i_wr_n);
  assign w_start = w_strb & ~r_strobe_q & ~r_done;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_strobe_q <= 1'b0;
      r_pend     <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
    end else begin
      r_strobe_q <= w_strb;
      if (w_start) begin
        r_addr  <= i_a;
        r_wdata <= i_do;
        r_we    <= ~i_wr_n;
        r_pend  <= 1'b1;
      end
      if (i_complete) r_pend <= 1'b0;
      // A strobe already gone at completion leaves nothing to guard against.
      if (!w_strb) r_done <= 1'b0;
      else if (i_complete) r_done <= 1'b1;
    end
  end

  // The start cycle forwards the live bus so the arbiter can grant without waiting for capture.
  assign o_req    = w_start | r_pend;
  assign o_wait_n = ~o_req;
  assign o_addr   = w_start ? i_a : r_addr;
  assign o_wdata  = w_start ? i_do : r_wdata;
  assign o_we     = w_start ? ~i_wr_n : r_we;

endmodule

// File: rtl/gb_mem_arbiter.sv
// Shares one memory port between the GameBoy CPU bus and a DMA requester, DMA deferred at most
// DMA_MAX_DEFER CPU grants; one decision cycle per grant, aborts with open-bus data on timeout.
module gb_mem_arbiter
  import gb_mem_arb_pkg::*;
#(
  parameter int AW            = 16,
  parameter int DMA_MAX_DEFER = 4,
  parameter int TIMEOUT       = 255
) (
  input logic             i_clk,
  input logic             i_reset_n,
  gb_mem_arbiter_if.slave bus
);

  localparam int DW = $clog2(DMA_MAX_DEFER + 2);

  arb_state_t    r_state;
  grant_src_t    w_pick;
  logic [DW-1:0] r_defer_cnt;
  logic [7:0]    r_tmo_cnt;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic [7:0]    r_cpu_di;
  logic [7:0]    r_dma_rdata;
  logic          r_dma_ack;
  logic          r_timeout_err;

  logic          w_cpu_req;
  logic          w_cpu_we;
  logic [AW-1:0] w_cpu_addr;
  logic [7:0]    w_cpu_wdata;
  logic          w_cpu_wait_n;
  logic          w_cpu_complete;
  logic          w_tmo_hit;
  logic          w_done;
  logic          w_defer_full;

  gb_cpu_strobe_capture #(.AW(AW)) u_strobe (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_mreq_n   (bus.cpu_mreq_n),
    .i_rd_n     (bus.cpu_rd_n),
    .i_wr_n     (bus.cpu_wr_n),
    .i_a        (bus.cpu_a),
    .i_do       (bus.cpu_do),
    .i_complete (w_cpu_complete),
    .o_req      (w_cpu_req),
    .o_wait_n   (w_cpu_wait_n),
    .o_addr     (w_cpu_addr),
    .o_wdata    (w_cpu_wdata),
    .o_we       (w_cpu_we)
  );

  assign w_tmo_hit      = (r_tmo_cnt == 8'(TIMEOUT - 1));
  assign w_done         = bus.mem_ack | w_tmo_hit;
  assign w_defer_full   = (r_defer_cnt == DW'(DMA_MAX_DEFER));
  assign w_pick         = (w_cpu_req && !(bus.dma_req && w_defer_full)) ? SRC_CPU : SRC_DMA;
  assign w_cpu_complete = (r_state == CPU_ACC) && w_done;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_defer_cnt   <= '0;
      r_tmo_cnt     <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_cpu_di      <= '0;
      r_dma_rdata   <= '0;
      r_dma_ack     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dma_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cpu_req || bus.dma_req) begin
            r_mem_req <= 1'b1;
            r_tmo_cnt <= '0;
            if (w_pick == SRC_CPU) begin
              r_state     <= CPU_ACC;
              r_mem_we    <= w_cpu_we;
              r_mem_addr  <= w_cpu_addr;
              r_mem_wdata <= w_cpu_wdata;
              if (bus.dma_req) r_defer_cnt <= r_defer_cnt + DW'(1);
            end else begin
              r_state     <= DMA_ACC;
              r_mem_we    <= bus.dma_we;
              r_mem_addr  <= bus.dma_addr;
              r_mem_wdata <= bus.dma_wdata;
            end
          end
        end
        CPU_ACC, DMA_ACC: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            // An ack arriving with the timeout still counts as a clean completion.
            if (!bus.mem_ack) r_timeout_err <= 1'b1;
            if (r_state == CPU_ACC) begin
              if (!bus.mem_ack) r_cpu_di <= OPEN_BUS;
              else if (!r_mem_we) r_cpu_di <= bus.mem_rdata;
            end else begin
              r_dma_ack   <= 1'b1;
              r_dma_rdata <= bus.mem_ack ? bus.mem_rdata : OPEN_BUS;
              r_defer_cnt <= '0;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_di      = r_cpu_di;
  assign bus.cpu_wait_n  = w_cpu_wait_n;
  assign bus.dma_rdata   = r_dma_rdata;
  assign bus.dma_ack     = r_dma_ack;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: doc/gb_mem_arbiter.md
Name: gb_mem_arbiter

Overview:
- Shares one external memory port (SDRAM controller front end) between the GameBoy CPU bus and one DMA requester (OAM DMA / GBC HDMA engine).
- Detects CPU memory strobes (MREQ_n with RD_n or WR_n) and captures address and data.
- Stalls the CPU through WAIT_n until the memory acknowledges. Serves DMA in the gaps, with a bounded-starvation priority rule.
- Sits between the GBse CPU wrapper and the SDRAM controller; IORQ cycles bypass this block.

Parameters:
- AW, 16: memory address width (CPU and DMA).
- DMA_MAX_DEFER, 4: consecutive CPU grants allowed while DMA waits before DMA is forced ahead.
- TIMEOUT, 255: cycles without mem_ack before a grant is aborted (8-bit counter, 1..255).

Ports:
- CLK_n  in  1  system clock; all logic on rising edge.
- RESET_n  in  1  synchronous active-low reset.
- cpu_mreq_n  in  1  CPU MREQ_n.
- cpu_rd_n  in  1  CPU RD_n.
- cpu_wr_n  in  1  CPU WR_n.
- cpu_a  in  AW  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_di  out  8  read data to CPU DI; held until the next CPU read completes.
- cpu_wait_n  out  1  CPU WAIT_n; low while a CPU access is outstanding.
- dma_req  in  1  DMA request level; must stay high with stable addr/we/wdata until dma_ack.
- dma_we  in  1  DMA write enable.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  8  DMA write data.
- dma_rdata  out  8  DMA read data; valid in the dma_ack cycle.
- dma_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle memory completion.
- timeout_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values: cpu_di=0, cpu_wait_n=1, dma_rdata=0, dma_ack=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout_err=0.
- Reset state: FSM=IDLE, defer_cnt=0, cpu_pend=0, cpu_done=0, strobe_q=0.
- A reset in the middle of an access drops mem_req on the next edge; the outstanding ack is discarded.
- CPU strobe: strb = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n).
- CPU start: cpu_start = strb & ~strobe_q & ~cpu_done. On cpu_start, register cpu_a, cpu_do and cpu_we = ~cpu_wr_n, and set cpu_pend.
- cpu_wait_n is combinational: ~(cpu_start | cpu_pend). WAIT_n therefore falls in the same cycle as the strobe edge.
- cpu_done is set on CPU completion and cleared when strb deasserts. This prevents a re-trigger while RD_n/WR_n remain low after the ack.
- FSM states: IDLE, CPU_ACC, DMA_ACC.
- IDLE, both CPU request (cpu_pend or cpu_start) and dma_req present:
  - If defer_cnt == DMA_MAX_DEFER, go to DMA_ACC.
  - Otherwise go to CPU_ACC and increment defer_cnt.
- IDLE, CPU request only: go to CPU_ACC; defer_cnt is unchanged.
- IDLE, dma_req only: go to DMA_ACC.
- Entering a grant: drive mem_req=1 and mem_addr/mem_we/mem_wdata from the granted source, registered. Memory sees mem_req one cycle after the decision.
- CPU_ACC on mem_ack:
  - If read, cpu_di <= mem_rdata.
  - Clear cpu_pend, set cpu_done, mem_req=0, go to IDLE.
  - cpu_wait_n is high in the following cycle.
- DMA_ACC on mem_ack:
  - dma_ack=1 for one cycle; dma_rdata <= mem_rdata.
  - defer_cnt=0, mem_req=0, go to IDLE.
- Back-to-back operation: IDLE decides in the same cycle it is entered, so a new grant can start every 2 cycles at mem_ack latency 1.
- mem_ack in IDLE is ignored.
- Timeout: a counter increments while in CPU_ACC or DMA_ACC without mem_ack. At TIMEOUT:
  - Set timeout_err, drop mem_req and go to IDLE.
  - A CPU access completes with cpu_di=8'hFF (open-bus value).
  - A DMA access completes with dma_ack and dma_rdata=8'hFF.
- mem_ack and timeout in the same cycle: mem_ack wins and no error is flagged.
- dma_req dropping before dma_ack is a protocol violation and does not abort an active grant.

Decomposition:
- Package gb_mem_arb_pkg: FSM state enum (IDLE/CPU_ACC/DMA_ACC), OPEN_BUS=8'hFF constant, grant-source enum.
- Sub-module gb_cpu_strobe_capture: strobe edge detection, cpu_pend/cpu_done flags, address/data capture, cpu_wait_n generation.

Test Plan:
- CPU read at A=16'hC000, mem_ack 3 cycles after mem_req, mem_rdata=8'h5A -> WAIT_n low from the strobe cycle; cpu_di=8'h5A; WAIT_n high 1 cycle after ack; no second request while RD_n stays low.
- CPU write A=16'hFF80 with DO=8'h3C -> mem_we=1, mem_addr=16'hFF80, mem_wdata=8'h3C; single mem_req.
- DMA alone, read 16'hC100 returning 8'h77 -> dma_ack pulses once with dma_rdata=8'h77.
- Continuous CPU traffic plus dma_req held, DMA_MAX_DEFER=4 -> exactly 4 CPU grants, then a DMA grant, then defer_cnt=0 and the pattern repeats.
- No mem_ack for 255 cycles during a CPU read -> timeout_err=1, cpu_di=8'hFF, WAIT_n released, FSM back in IDLE.
- RESET_n low for one cycle during DMA_ACC -> mem_req=0, dma_ack=0, cpu_wait_n=1 next cycle; a late mem_ack is ignored.
